// File: rtl/booth_mac_seq.sv
// Sequencer and accumulator for an 8-bit sequential Booth multiplier: issues operand
// pairs one at a time, sums the signed products and reports each group on a handshake.
module booth_mac_seq #(
    parameter int ACC_W   = 24,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    input  logic             in_last,
    output logic             mul_start,
    output logic [7:0]       mul_x,
    output logic [7:0]       mul_y,
    input  logic             mul_valid,
    input  logic [15:0]      mul_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             out_ovf,
    output logic             err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACCUM,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mulX_q, mulX_d;
    logic [7:0]       mulY_q, mulY_d;
    logic             last_q, last_d;
    logic [7:0]       timer_q, timer_d;
    logic [15:0]      prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             errTimeout_q, errTimeout_d;

    logic [ACC_W-1:0] prodExt;
    logic [ACC_W-1:0] sum;
    logic             sumOvf;

    // Overflow: both addends share a sign that the wrapped sum does not.
    assign prodExt = ACC_W'($signed(prod_q));
    assign sum     = acc_q + prodExt;
    assign sumOvf  = (acc_q[ACC_W-1] == prodExt[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mulX_q       <= '0;
            mulY_q       <= '0;
            last_q       <= 1'b0;
            timer_q      <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            errTimeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mulX_q       <= mulX_d;
            mulY_q       <= mulY_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            errTimeout_q <= errTimeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mulX_d       = mulX_q;
        mulY_d       = mulY_q;
        last_d       = last_q;
        timer_d      = timer_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        errTimeout_d = 1'b0;
        mul_start    = 1'b0;
        out_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mulX_d  = in_x;
                    mulY_d  = in_y;
                    last_d  = in_last;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                timer_d   = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // mul_valid wins over the timeout in the last permitted cycle.
                timer_d = timer_q + 8'd1;
                if (mul_valid) begin
                    prod_d  = mul_z;
                    state_d = S_ACCUM;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    errTimeout_d = 1'b1;
                    acc_d        = '0;
                    count_d      = '0;
                    ovf_d        = 1'b0;
                    last_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            S_ACCUM: begin
                acc_d   = sum;
                ovf_d   = ovf_q | sumOvf;
                count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign mul_x       = mulX_q;
    assign mul_y       = mulY_q;
    assign out_acc     = acc_q;
    assign out_count   = count_q;
    assign out_ovf     = ovf_q;
    assign err_timeout = errTimeout_q;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Randomized bench for booth_mac_seq: a multiplier model answers start pulses and a
// group-level arithmetic model predicts every result (24-bit and 16-bit accumulators).
module tb_booth_mac_seq;

    localparam int     TMO    = 16;
    localparam longint MASK24 = 64'hFFFFFF;
    localparam longint MASK16 = 64'hFFFF;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_x, in_y;
    logic        mul_start, mul_valid;
    logic [7:0]  mul_x, mul_y;
    logic [15:0] mul_z;
    logic        out_valid, out_ready, out_ovf, err_timeout;
    logic [23:0] out_acc;
    logic [7:0]  out_count;

    logic        in_ready16, mul_start16, out_valid16, out_ovf16, err16;
    logic [7:0]  mul_x16, mul_y16, out_count16;
    logic [15:0] out_acc16;

    booth_mac_seq #(.ACC_W(24), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
        .mul_valid(mul_valid), .mul_z(mul_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_count(out_count), .out_ovf(out_ovf), .err_timeout(err_timeout)
    );

    booth_mac_seq #(.ACC_W(16), .TIMEOUT(TMO)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_x(in_x), .in_y(in_y), .in_last(in_last),
        .mul_start(mul_start16), .mul_x(mul_x16), .mul_y(mul_y16),
        .mul_valid(mul_valid), .mul_z(mul_z),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16),
        .out_count(out_count16), .out_ovf(out_ovf16), .err_timeout(err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint acc24;
        longint acc16;
        int     count;
        bit     ovf24;
        bit     ovf16;
    } grp_t;

    grp_t   expQ[$];
    grp_t   lastPush;
    longint mAcc24, mAcc16;
    int     mCount;
    bit     mOvf24, mOvf16;

    int     nVec = 0, nMis = 0;
    longint cyc = 0;
    longint expErrCyc = -1;
    int     startCnt = 0, acceptCnt = 0, errCnt = 0;
    logic [7:0] expOpX = 0, expOpY = 0;
    longint lastAcc24 = 0, lastAcc16 = 0;
    int     lastCount = 0;
    bit     lastOvf24 = 0, lastOvf16 = 0;
    bit     mulNoResp = 0, spurEn = 1, waitFlag = 0;
    int     forceLat = 0, rdyForce = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void checkOutput(string name, longint act, longint exp);
        nVec++;
        if (act != exp) begin
            nMis++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic longint wrapS(longint s, int w);
        longint m, r;
        m = longint'(1) << w;
        r = s & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    function automatic void modelClear();
        mAcc24 = 0; mAcc16 = 0; mCount = 0; mOvf24 = 0; mOvf16 = 0;
    endfunction

    // Exact sum in 64 bits; overflow whenever it leaves the signed range of the width.
    function automatic void modelAdd(longint p);
        longint s;
        s = mAcc24 + p;
        if (s > (longint'(1) << 23) - 1 || s < -(longint'(1) << 23)) mOvf24 = 1;
        mAcc24 = wrapS(s, 24);
        s = mAcc16 + p;
        if (s > (longint'(1) << 15) - 1 || s < -(longint'(1) << 15)) mOvf16 = 1;
        mAcc16 = wrapS(s, 16);
        mCount = (mCount < 255) ? mCount + 1 : 255;
    endfunction

    // Multiplier model: answers each start after 1..8 cycles, or never when muted.
    initial begin
        bit pend;
        int cnt;
        pend = 0; cnt = 0;
        mul_valid = 1'b0;
        mul_z = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                pend = 0;
                mul_valid = 1'b0;
                continue;
            end
            mul_valid = 1'b0;
            if (mul_start) begin
                if (mulNoResp) expErrCyc = cyc + 1 + TMO;
                else begin
                    pend = 1;
                    cnt = (forceLat > 0) ? forceLat : $urandom_range(1, 8);
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    mul_valid = 1'b1;
                    mul_z = 16'(int'($signed(mul_x)) * int'($signed(mul_y)));
                end
            end else if (spurEn && !mulNoResp && $urandom_range(0, 5) == 0) begin
                mul_valid = 1'b1;
                mul_z = 16'($urandom);
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #3;
            case (rdyForce)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Compare process: reset values, operand stability, timeout timing, group results.
    initial begin
        grp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                waitFlag = 0;
                checkOutput("rstCtl", longint'({in_ready, mul_start, out_valid, out_ovf, err_timeout}), 0);
                checkOutput("rstMulXY", longint'({mul_x, mul_y}), 0);
                checkOutput("rstAcc", longint'(out_acc), 0);
                checkOutput("rstCount", longint'(out_count), 0);
                checkOutput("rstDut16", longint'({in_ready16, mul_start16, out_valid16, out_ovf16,
                                                   err16, mul_x16, mul_y16, out_acc16, out_count16}), 0);
                continue;
            end
            checkOutput("dut16Lockstep",
                        longint'({in_ready16, mul_start16, mul_x16, mul_y16, out_valid16, out_count16, err16}),
                        longint'({in_ready, mul_start, mul_x, mul_y, out_valid, out_count, err_timeout}));
            checkOutput("errTimeout", longint'(err_timeout), longint'(cyc == expErrCyc));
            if (err_timeout) begin
                waitFlag = 0;
                errCnt++;
                checkOutput("errInReady", longint'(in_ready), 1);
            end
            if (mul_start || waitFlag) begin
                checkOutput("mulX", longint'(mul_x), longint'(expOpX));
                checkOutput("mulY", longint'(mul_y), longint'(expOpY));
                checkOutput("busyInReady", longint'(in_ready), 0);
                if (waitFlag && mul_valid) waitFlag = 0;
            end
            if (mul_start) begin
                startCnt++;
                waitFlag = 1;
            end
            if (out_valid) begin
                if (expQ.size() == 0) checkOutput("outUnexpected", longint'(out_valid), 0);
                else begin
                    e = expQ[0];
                    checkOutput("outAcc24", longint'(out_acc), e.acc24 & MASK24);
                    checkOutput("outAcc16", longint'(out_acc16), e.acc16 & MASK16);
                    checkOutput("outCount", longint'(out_count), longint'(e.count));
                    checkOutput("outOvf24", longint'(out_ovf), longint'(e.ovf24));
                    checkOutput("outOvf16", longint'(out_ovf16), longint'(e.ovf16));
                    checkOutput("outInReady", longint'(in_ready), 0);
                    if (out_ready) begin
                        lastAcc24 = longint'(out_acc);
                        lastAcc16 = longint'(out_acc16);
                        lastCount = int'(out_count);
                        lastOvf24 = out_ovf;
                        lastOvf16 = out_ovf16;
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    task automatic sendPair(input logic [7:0] x, input logic [7:0] y, input logic last, output bit ok);
        int n;
        n = 0;
        ok = 0;
        while (n < 300) begin
            if (in_ready) begin
                in_valid = 1'b1; in_x = x; in_y = y; in_last = last;
                @(posedge clk); #1;
                in_valid = 1'b0;
                expOpX = x;
                expOpY = y;
                ok = 1;
                return;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_x = 8'($urandom); in_y = 8'($urandom); in_last = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        checkOutput("acceptTimeout", longint'(in_ready), 1);
    endtask

    task automatic applyStimulus(input int x, input int y, input bit last);
        bit ok;
        grp_t e;
        sendPair(8'(x), 8'(y), last, ok);
        if (!ok) return;
        acceptCnt++;
        if (mulNoResp) modelClear();
        else begin
            modelAdd(longint'(x * y));
            if (last) begin
                e.acc24 = mAcc24; e.acc16 = mAcc16; e.count = mCount;
                e.ovf24 = mOvf24; e.ovf16 = mOvf16;
                expQ.push_back(e);
                lastPush = e;
                modelClear();
            end
        end
    endtask

    // Idles the input (valid low, data churning) until results are out and IDLE is back.
    task automatic drain();
        int n;
        n = 0;
        do begin
            in_valid = 1'b0;
            in_x = 8'($urandom); in_y = 8'($urandom); in_last = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end while (!(in_ready && expQ.size() == 0) && n < 400);
        if (n >= 400) begin
            checkOutput("drainReady", longint'(in_ready), 1);
            checkOutput("drainQueue", longint'(expQ.size()), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s0, e0, n;
        bit ok;
        modelClear();
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("relInReady", longint'(in_ready), 1);
        checkOutput("relAcc", longint'(out_acc), 0);
        @(posedge clk); #1;

        s0 = startCnt;
        applyStimulus(3, 4, 0);
        applyStimulus(-5, 6, 1);
        drain();
        checkOutput("t1ModelAcc", lastPush.acc24 & MASK24, 64'hFFFFEE);
        checkOutput("t1Acc", lastAcc24, 64'hFFFFEE);
        checkOutput("t1Count", longint'(lastCount), 2);
        checkOutput("t1Ovf", longint'(lastOvf24), 0);
        checkOutput("t1Starts", longint'(startCnt - s0), 2);

        applyStimulus(-128, -128, 1);
        drain();
        checkOutput("t2Acc24", lastAcc24, 64'h004000);
        checkOutput("t2Acc16", lastAcc16, 64'h4000);
        checkOutput("t2Count", longint'(lastCount), 1);
        applyStimulus(-128, -128, 0);
        applyStimulus(-128, -128, 1);
        drain();
        checkOutput("t2Two16", lastAcc16, 64'h8000);
        checkOutput("t2TwoOvf16", longint'(lastOvf16), 1);
        for (int i = 0; i < 4; i++) applyStimulus(-128, -128, i == 3);
        drain();
        checkOutput("t2ModelAcc16", lastPush.acc16 & MASK16, 0);
        checkOutput("t2Four16", lastAcc16, 0);
        checkOutput("t2FourOvf16", longint'(lastOvf16), 1);
        checkOutput("t2Four24", lastAcc24, 64'h010000);
        checkOutput("t2FourOvf24", longint'(lastOvf24), 0);

        rdyForce = 1;
        applyStimulus(1, 2, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 40);
        checkOutput("bpWait", longint'(out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("bpValid", longint'(out_valid), 1);
            checkOutput("bpAcc", longint'(out_acc), 2);
            checkOutput("bpInReady", longint'(in_ready), 0);
        end
        @(posedge clk); #1 rdyForce = 2;
        @(posedge clk); #1 rdyForce = 0;
        @(negedge clk);
        checkOutput("bpRelInReady", longint'(in_ready), 1);
        checkOutput("bpRelAcc", longint'(out_acc), 0);
        checkOutput("bpRelValid", longint'(out_valid), 0);
        @(posedge clk); #1;

        forceLat = 8;
        applyStimulus(7, -9, 1);
        drain();
        checkOutput("t4Acc", lastAcc24, 64'hFFFFC1);
        e0 = errCnt;
        forceLat = TMO;
        applyStimulus(3, -3, 1);
        drain();
        forceLat = 0;
        checkOutput("t4LateAcc", lastAcc24, 64'hFFFFF7);
        checkOutput("t4LateNoErr", longint'(errCnt - e0), 0);

        applyStimulus(3, 3, 0);
        drain();
        e0 = errCnt;
        spurEn = 0; mulNoResp = 1;
        applyStimulus(5, 5, 0);
        drain();
        @(negedge clk);
        checkOutput("t5ErrPulses", longint'(errCnt - e0), 1);
        @(posedge clk); #1;
        mulNoResp = 0; spurEn = 1;
        applyStimulus(2, 2, 1);
        drain();
        checkOutput("t5Acc", lastAcc24, 4);
        checkOutput("t5Count", longint'(lastCount), 1);

        forceLat = 6;
        applyStimulus(3, 3, 0);
        sendPair(8'd6, 8'd7, 1'b1, ok);
        acceptCnt++;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        modelClear();
        @(negedge clk);
        checkOutput("t6InReady", longint'(in_ready), 1);
        checkOutput("t6Acc", longint'(out_acc), 0);
        @(posedge clk); #1;
        forceLat = 0;
        applyStimulus(1, 1, 1);
        drain();
        checkOutput("t6GroupAcc", lastAcc24, 1);
        checkOutput("t6GroupCount", longint'(lastCount), 1);

        for (int g = 0; g < 40; g++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                int x, y;
                x = ($urandom_range(0, 3) == 0) ? -128 : int'($signed(8'($urandom)));
                y = ($urandom_range(0, 3) == 0) ? 127 : int'($signed(8'($urandom)));
                applyStimulus(x, y, i == len - 1);
            end
            drain();
        end

        for (int i = 0; i < 260; i++)
            applyStimulus(int'($signed(8'($urandom))), int'($signed(8'($urandom))), i == 259);
        drain();
        checkOutput("satCount", longint'(lastCount), 255);

        checkOutput("queueEmpty", longint'(expQ.size()), 0);
        checkOutput("startsPerPair", longint'(startCnt), longint'(acceptCnt));
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
